// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU constants and divider state encoding
package alu_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_LATENCY = DIV_WIDTH + 1;
    localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_trial_sub.sv
// rtl/div_trial_sub.sv - restoring-division trial subtraction at WIDTH+1 bits
module div_trial_sub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a_shifted,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] diff,
    output logic             neg
);

    logic [WIDTH:0] full;

    // Since A < M before the shift, the true difference fits in WIDTH+1 signed bits.
    assign full = a_shifted - {1'b0, m};
    assign diff = full[WIDTH-1:0];
    assign neg  = full[WIDTH];

endmodule

// File: rtl/div_32_bit.sv
// rtl/div_32_bit.sv - multi-cycle signed restoring divider, one quotient bit per clock
module div_32_bit
    import alu_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] m_reg;
    logic             qneg;
    logic             rneg;
    logic [CW-1:0]    count;

    logic [WIDTH:0]   a_shifted;
    logic [WIDTH-1:0] trial_diff;
    logic             trial_neg;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    assign a_shifted = {a_reg, q_reg[WIDTH-1]};

    div_trial_sub #(.WIDTH(WIDTH)) u_trial (
        .a_shifted (a_shifted),
        .m         (m_reg),
        .diff      (trial_diff),
        .neg       (trial_neg)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            state       <= IDLE;
            a_reg       <= '0;
            q_reg       <= '0;
            m_reg       <= '0;
            qneg        <= 1'b0;
            rneg        <= 1'b0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            a_reg       <= '0;
                            q_reg       <= magnitude(dividend);
                            m_reg       <= magnitude(divisor);
                            qneg        <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                            rneg        <= dividend[WIDTH-1];
                            count       <= '0;
                            busy        <= 1'b1;
                            div_by_zero <= 1'b0;
                            state       <= CALC;
                        end
                    end
                end
                CALC: begin
                    a_reg <= trial_neg ? a_shifted[WIDTH-1:0] : trial_diff;
                    q_reg <= {q_reg[WIDTH-2:0], ~trial_neg};
                    count <= count + 1'b1;
                    if (count == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    quotient  <= qneg ? -q_reg : q_reg;
                    remainder <= rneg ? -a_reg : a_reg;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_32_bit.sv
// tb/tb_div_32_bit.sv - table-driven self-checking bench for div_32_bit
module tb_div_32_bit;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    div_32_bit #(.WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [31:0] dd;
        logic [31:0] dv;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Counts edges after the accept edge until done is seen; lat starts at lat0.
    task automatic wait_done(input int lat0, output int lat, output bit all_busy, output bit seen);
        lat = lat0;
        all_busy = 1'b1;
        seen = 1'b0;
        while (lat <= 100) begin
            @(negedge clock);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (!busy) all_busy = 1'b0;
            @(posedge clock);
            lat++;
        end
    endtask

    task automatic accept(input logic [31:0] dd, input logic [31:0] dv);
        @(negedge clock);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    task automatic check_result(input string name, input int lat, input bit all_busy, input bit seen,
                                input logic [31:0] q, input logic [31:0] r, input logic dz, input int elat);
        chk({name, " done_seen"}, 32'(seen), 32'd1);
        chk({name, " latency"}, lat, elat);
        chk({name, " busy_during"}, 32'(all_busy), 32'd1);
        chk({name, " busy_at_done"}, 32'(busy), 32'd0);
        chk({name, " quotient"}, quotient, q);
        chk({name, " remainder"}, remainder, r);
        chk({name, " div_by_zero"}, 32'(div_by_zero), 32'(dz));
        @(negedge clock);
        chk({name, " done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  lat;
        bit  all_busy;
        bit  seen;
        bit  done_late;

        vecs.push_back('{"100/7",      32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33});
        vecs.push_back('{"-100/7",     32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 33});
        vecs.push_back('{"100/-7",     32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 33});
        vecs.push_back('{"-100/-7",    32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 33});
        vecs.push_back('{"min/-1",     32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33});
        vecs.push_back('{"min/1",      32'h80000000,   32'd1,          32'h80000000,   32'd0,          1'b0, 33});
        vecs.push_back('{"5/0",        32'd5,          32'd0,          32'hFFFFFFFF,   32'd5,          1'b1, 0});
        vecs.push_back('{"9/3",        32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 33});
        vecs.push_back('{"-1/min",     32'hFFFFFFFF,   32'h80000000,   32'd0,          32'hFFFFFFFF,   1'b0, 33});
        vecs.push_back('{"max/min",    32'h7FFFFFFF,   32'h80000000,   32'd0,          32'h7FFFFFFF,   1'b0, 33});
        vecs.push_back('{"min/min",    32'h80000000,   32'h80000000,   32'd1,          32'd0,          1'b0, 33});
        vecs.push_back('{"min/2",      32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0, 33});
        vecs.push_back('{"-7/2",       32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 33});
        vecs.push_back('{"0/5",        32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33});
        vecs.push_back('{"-8/0",       32'hFFFFFFF8,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFF8,   1'b1, 0});

        clear    = 1'b1;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        repeat (2) @(posedge clock);
        #1 clear = 1'b0;
        @(negedge clock);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset div_by_zero", 32'(div_by_zero), 32'd0);

        foreach (vecs[i]) begin
            accept(vecs[i].dd, vecs[i].dv);
            wait_done(0, lat, all_busy, seen);
            if (vecs[i].dz) all_busy = 1'b1;
            check_result(vecs[i].name, lat, all_busy, seen, vecs[i].q, vecs[i].r, vecs[i].dz, vecs[i].lat);
        end

        // Results hold while idle.
        repeat (3) @(negedge clock);
        chk("hold quotient", quotient, 32'hFFFFFFFF);
        chk("hold remainder", remainder, 32'hFFFFFFF8);

        // A start while busy is ignored.
        accept(32'd1000, 32'd3);
        all_busy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (!busy) all_busy = 1'b0;
            @(posedge clock);
        end
        @(negedge clock);
        dividend = 32'd8;
        divisor  = 32'd2;
        start    = 1'b1;
        @(posedge clock);
        #1 start = 1'b0;
        begin
            bit b2;
            wait_done(6, lat, b2, seen);
            all_busy = all_busy & b2;
        end
        check_result("ignore_start", lat, all_busy, seen, 32'd333, 32'd1, 1'b0, 33);

        // Clear mid-operation discards the result.
        accept(32'd1000, 32'd3);
        repeat (9) @(posedge clock);
        @(negedge clock);
        clear = 1'b1;
        @(posedge clock);
        #1 clear = 1'b0;
        @(negedge clock);
        chk("clear busy", 32'(busy), 32'd0);
        chk("clear done", 32'(done), 32'd0);
        chk("clear quotient", quotient, 32'd0);
        chk("clear remainder", remainder, 32'd0);
        done_late = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (done || busy) done_late = 1'b1;
        end
        chk("clear no_done", 32'(done_late), 32'd0);

        accept(32'd7, 32'd7);
        wait_done(0, lat, all_busy, seen);
        check_result("7/7", lat, all_busy, seen, 32'd1, 32'd0, 1'b0, 33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
